spi_periph_bridge: RTL
======================

Name: spi_periph_bridge

Overview:
- SPI-slave-to-peripheral-bus bridge. Gives an external SPI host read/write access to N_CH TinyQV-style peripherals in the test harness.
- Generalises the single-peripheral SPI register access with:
  - a channel-select field
  - read wait-states that end on data_ready or on a timeout
  - width-masked read data
  - interrupt aggregation
- SPI inputs arrive already 2-stage synchronised to clk. The bridge owns the entire bus-side handshake.

Parameters:
- N_CH, 4, number of peripheral channels (1..8).
- SEL_W, 2, channel-select field width; must satisfy 2^SEL_W >= N_CH.
- ADDR_W, 6, peripheral register address width.
- TIMEOUT, 15, maximum clk cycles to wait for data_ready on a read (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_cs_n  in  1  synchronised chip select, active low
- spi_clk  in  1  synchronised SPI clock, mode 0
- spi_mosi  in  1  synchronised host data
- spi_miso  out  1  bridge data to host
- address  out  ADDR_W  register address, shared by all channels
- data_in  out  32  write data, shared by all channels
- data_write_n  out  2*N_CH  per-channel write strobe pair; 11 = idle, else txn width
- data_read_n  out  2*N_CH  per-channel read request pair; 11 = idle, else txn width
- data_out  in  32*N_CH  per-channel read data
- data_ready  in  N_CH  per-channel read data valid
- user_interrupt  in  N_CH  per-channel interrupt
- irq  out  1  OR of user_interrupt, registered
- busy  out  1  high from the first header bit until the frame completes or aborts
- timeout_err  out  1  sticky; set when a read times out; cleared by reset or by a write to channel N_CH-1, address all-ones

Behaviour:
- Reset values: spi_miso=0, address=0, data_in=0, all data_write_n/data_read_n bits=1, irq=0, busy=0, timeout_err=0. FSM returns to IDLE.
- Edge detection:
  - The bridge registers the previous spi_clk value.
  - Rising edge = sample spi_mosi.
  - Falling edge = shift spi_miso.
  - Edges are acted on in the clk cycle they are detected.
- Frame format, MSB first:
  - Header: rw(1, 1=write), width(2), sel(SEL_W), addr(ADDR_W). Header length H = 3+SEL_W+ADDR_W bits.
  - Then data of D bits: D=8 for width 00, 16 for 01, 32 for 10 and 11. Width 11 is driven on the bus as 10.
- FSM states: IDLE, HDR, WDATA, WSTROBE, RWAIT, RDATA.
  - IDLE -> HDR when cs_n falls.
  - HDR: after the H-th bit, latch address/sel/width. Go to WDATA if rw=1, else RWAIT.
  - WDATA: after D bits, data_in is the data right-aligned, upper bits zero. Go to WSTROBE.
  - WSTROBE: data_write_n[2*sel+:2]=width for exactly 1 clk, then go to IDLE-wait. Writes do not wait for data_ready.
  - RWAIT:
    - Hold data_read_n[2*sel+:2]=width.
    - When data_ready[sel]=1 is sampled: capture data_out[sel], masked (width 00 keeps [7:0], 01 keeps [15:0], others keep all 32 bits). Release data_read_n the next cycle. Go to RDATA.
    - After TIMEOUT cycles without data_ready: capture 0, set timeout_err, go to RDATA.
    - The request is asserted on the clk after the last header bit.
  - RDATA:
    - spi_miso = MSB of the D-bit shift register (bit D-1).
    - The register shifts on each spi_clk falling edge.
    - After D rising edges the frame is complete.
    - The host must leave at least TIMEOUT+3 clk between the last header rising edge and the first data rising edge. Falling edges during RWAIT are ignored.
- Out-of-range sel (>= N_CH): no strobe or request is issued; reads return 0 immediately with no timeout and no error.
- cs_n rising at any point aborts the frame:
  - all strobes/requests are released the next cycle
  - no partial write is issued
  - FSM goes to IDLE, busy=0
  - a WSTROBE already issued is not retracted
- spi_clk edges while cs_n=1 are ignored. Extra clocks after frame completion are ignored until cs_n has been high for at least 1 clk.
- At most one channel's strobe pair is non-11 in any cycle.
- irq = |user_interrupt, 1-cycle registered latency.

Test Plan:
- Write, width 10, sel 1, addr 0x05, data 0xCAFEF00D -> one-cycle data_write_n[3:2]=10, address=0x05, data_in=0xCAFEF00D; other pairs stay 11.
- Read, width 00, sel 2; data_ready[2] rises 3 clk after request; data_out[2]=0x12345678 -> data_read_n[5:4]=00 for 4 cycles; host receives 0x78.
- Read, width 01, sel 0; data_ready never asserted -> request held exactly 15 cycles, released; host receives 0x0000; timeout_err=1 and stays 1 until reset.
- Write, sel 0; cs_n raised after 10 data bits -> no data_write_n pulse; busy=0 two clk later; next full frame works normally.
- Read, sel 3 with N_CH=3 -> no request on any channel; host receives 0; timeout_err unchanged.
- user_interrupt=0b0100 -> irq=1 one clk later; user_interrupt=0 -> irq=0 one clk later. Reset asserted mid-RWAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/spi_periph_bridge.sv
// Purpose : SPI mode-0 slave that turns host frames into read/write accesses on N_CH TinyQV-style peripherals.
// Latency : write strobe 1 clk after the last data bit; read request 1 clk after the last header bit, held until data_ready or TIMEOUT.
// Backpres: none toward the host (fixed-timing SPI); peripheral reads stall on data_ready, bounded by TIMEOUT.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   spi_cs_n/clk/mosi/miso     SPI pins, inputs already synchronised to clk
//   address, data_in           shared peripheral address / write data
//   data_write_n, data_read_n  per-channel 2-bit strobe pairs (11 = idle, else bus width)
//   data_out, data_ready       per-channel read data and read-valid
//   user_interrupt, irq        per-channel interrupts and their registered OR
//   busy, timeout_err          frame-in-progress flag, sticky read-timeout flag
module spi_periph_bridge #(
    parameter int N_CH    = 4,
    parameter int SEL_W   = 2,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs_n,
    input  logic                 spi_clk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic [ADDR_W-1:0]    address,
    output logic [31:0]          data_in,
    output logic [2*N_CH-1:0]    data_write_n,
    output logic [2*N_CH-1:0]    data_read_n,
    input  logic [32*N_CH-1:0]   data_out,
    input  logic [N_CH-1:0]      data_ready,
    input  logic [N_CH-1:0]      user_interrupt,
    output logic                 irq,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int H = 3 + SEL_W + ADDR_W;
    localparam logic [7:0]       H_M1     = 8'(H - 1);
    localparam logic [7:0]       TO_M1    = 8'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_WDATA   = 3'd2;
    localparam logic [2:0] ST_WSTROBE = 3'd3;
    localparam logic [2:0] ST_RWAIT   = 3'd4;
    localparam logic [2:0] ST_RDATA   = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;   // frame finished, waiting for cs_n to go high

    // Strobe vector with only channel s driven; width 11 goes out as 10.
    // An out-of-range s matches no channel, so the vector stays all-idle.
    function automatic logic [2*N_CH-1:0] pair_vec(input logic [SEL_W-1:0] s, input logic [1:0] w);
        logic [2*N_CH-1:0] v;
        v = '1;
        for (int c = 0; c < N_CH; c++) begin
            if (s == SEL_W'(c)) v[2*c +: 2] = (w == 2'b11) ? 2'b10 : w;
        end
        return v;
    endfunction

    function automatic logic sel_hit(input logic [SEL_W-1:0] s);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (s == SEL_W'(c)) hit = 1'b1;
        end
        return hit;
    endfunction

    logic [2:0]        state_q, state_d;
    logic              spi_clk_q, cs_n_q;
    logic [H-2:0]      hdr_q, hdr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        wait_q, wait_d;
    logic [31:0]       sh_q, sh_d;
    logic [1:0]        width_q, width_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       data_in_q, data_in_d;
    logic [2*N_CH-1:0] wr_n_q, wr_n_d;
    logic [2*N_CH-1:0] rd_n_q, rd_n_d;
    logic              irq_q, busy_q, busy_d, terr_q, terr_d;

    logic              rise, fall, cs_fall;
    logic [H-1:0]      hdr_nxt;
    logic [1:0]        h_w;
    logic [SEL_W-1:0]  h_sel;
    logic [7:0]        d_m1;
    logic              rdy_sel;
    logic [31:0]       dat_sel, dat_mask;

    assign rise    = spi_clk & ~spi_clk_q;
    assign fall    = ~spi_clk & spi_clk_q;
    assign cs_fall = cs_n_q & ~spi_cs_n;
    assign hdr_nxt = {hdr_q, spi_mosi};
    assign h_w     = hdr_nxt[H-2 -: 2];
    assign h_sel   = hdr_nxt[ADDR_W +: SEL_W];

    always_comb begin
        case (width_q)
            2'b00:   d_m1 = 8'd7;
            2'b01:   d_m1 = 8'd15;
            default: d_m1 = 8'd31;
        endcase
    end

    always_comb begin
        rdy_sel = 1'b0;
        dat_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (sel_q == SEL_W'(c)) begin
                rdy_sel = data_ready[c];
                dat_sel = data_out[32*c +: 32];
            end
        end
        case (width_q)
            2'b00:   dat_mask = {24'd0, dat_sel[7:0]};
            2'b01:   dat_mask = {16'd0, dat_sel[15:0]};
            default: dat_mask = dat_sel;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        sh_d      = sh_q;
        width_d   = width_q;
        sel_d     = sel_q;
        address_d = address_q;
        data_in_d = data_in_q;
        wr_n_d    = wr_n_q;
        rd_n_d    = rd_n_q;
        busy_d    = busy_q;
        terr_d    = terr_q;

        if (state_q != ST_IDLE && spi_cs_n) begin
            // cs_n high aborts anything in flight; a strobe already on the bus just ends normally.
            state_d = ST_IDLE;
            wr_n_d  = '1;
            rd_n_d  = '1;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_HDR;
                        cnt_d   = '0;
                    end
                end
                ST_HDR: begin
                    if (rise) begin
                        busy_d = 1'b1;
                        hdr_d  = hdr_nxt[H-2:0];
                        if (cnt_q == H_M1) begin
                            width_d   = h_w;
                            sel_d     = h_sel;
                            address_d = hdr_nxt[ADDR_W-1:0];
                            cnt_d     = '0;
                            wait_d    = '0;
                            sh_d      = '0;
                            if (hdr_nxt[H-1]) begin
                                state_d = ST_WDATA;
                            end else if (sel_hit(h_sel)) begin
                                state_d = ST_RWAIT;
                                rd_n_d  = pair_vec(h_sel, h_w);
                            end else begin
                                state_d = ST_RDATA;   // unmapped channel reads as zero
                            end
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        sh_d = {sh_q[30:0], spi_mosi};
                        if (cnt_q == d_m1) begin
                            data_in_d = {sh_q[30:0], spi_mosi};
                            wr_n_d    = pair_vec(sel_q, width_q);
                            state_d   = ST_WSTROBE;
                            if (sel_q == SEL_LAST && address_q == '1) terr_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_WSTROBE: begin
                    wr_n_d  = '1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
                ST_RWAIT: begin
                    if (rdy_sel) begin
                        sh_d    = dat_mask;
                        rd_n_d  = '1;
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end else if (wait_q == TO_M1) begin
                        sh_d    = '0;
                        rd_n_d  = '1;
                        terr_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RDATA;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                ST_RDATA: begin
                    if (rise) begin
                        if (cnt_q == d_m1) begin
                            busy_d  = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (fall && cnt_q != 8'd0) begin
                        // Only shift after the host has sampled a bit, so a late header
                        // falling edge cannot eat the MSB when data came back quickly.
                        sh_d = {sh_q[30:0], 1'b0};
                    end
                end
                default: ;  // ST_DONE: ignore extra clocks until cs_n goes high
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            spi_clk_q <= 1'b0;
            cs_n_q    <= 1'b1;
            hdr_q     <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            sh_q      <= '0;
            width_q   <= '0;
            sel_q     <= '0;
            address_q <= '0;
            data_in_q <= '0;
            wr_n_q    <= '1;
            rd_n_q    <= '1;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            spi_clk_q <= spi_clk;
            cs_n_q    <= spi_cs_n;
            hdr_q     <= hdr_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            sh_q      <= sh_d;
            width_q   <= width_d;
            sel_q     <= sel_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            irq_q     <= |user_interrupt;
            busy_q    <= busy_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        spi_miso = 1'b0;
        if (state_q == ST_RDATA) begin
            case (width_q)
                2'b00:   spi_miso = sh_q[7];
                2'b01:   spi_miso = sh_q[15];
                default: spi_miso = sh_q[31];
            endcase
        end
    end

    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;
    assign irq          = irq_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule
